prog_loader: RTL and testbench

Program-memory loader: the write side of the 2K×14 instruction store that the core's fetch path reads. It accepts a framed byte stream over a valid/ready handshake and assembles 14-bit instruction words. Words are written at incrementing addresses from 0, the frame checksum is checked, and the CPU is held in reset for the whole load. It sits between the host byte link (UART receiver) and the program RAM write port.

---
 rtl/pic_pkg.sv | 26 ++
 rtl/prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_prog_loader.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pic_pkg : shared program-memory constants and loader state type    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package pic_pkg;

  localparam int         PM_ADDR_W  = 11;
  localparam int         PM_DATA_W  = 14;
  localparam logic [7:0] LOADER_HDR = 8'hA5;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HDR   = 4'd1,
    LEN_H = 4'd2,
    LEN_L = 4'd3,
    W_HI  = 4'd4,
    W_LO  = 4'd5,
    WRITE = 4'd6,
    CSUM  = 4'd7,
    DONE  = 4'd8,
    ERR   = 4'd9
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | prog_loader : framed byte stream -> program RAM write port loader  |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module prog_loader
  import pic_pkg::*;
#(
  parameter int         ADDR_W   = PM_ADDR_W,
  parameter int         DATA_W   = PM_DATA_W,
  parameter logic [7:0] HDR_BYTE = LOADER_HDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] Pm_addr_out,
  output logic [DATA_W-1:0] Pm_data_out,
  output logic              Pm_we_out,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [DATA_W-9:0] hi_q, hi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              xfer;
  logic [15:0]       len_w;
  logic [ADDR_W:0]   cnt_inc;

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      HDR, LEN_H, LEN_L, W_HI, W_LO, CSUM: byte_ready = 1'b1;
      default:                             byte_ready = 1'b0;
    endcase
  end

  assign xfer    = byte_valid && byte_ready;
  assign len_w   = {len_q[15:8], byte_in};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          addr_d  = '0;
          cnt_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      HDR: begin
        if (xfer) begin
          if (byte_in == HDR_BYTE) begin
            state_d = LEN_H;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end
        end
      end
      LEN_H: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          state_d     = LEN_L;
        end
      end
      LEN_L: begin
        if (xfer) begin
          len_d = len_w;
          if (len_w == 16'd0 || {1'b0, len_w} > MAX_N) begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = W_HI;
          end
        end
      end
      W_HI: begin
        if (xfer) begin
          // Only the low six bits of HI belong to the instruction word.
          if (byte_in[7:6] != 2'b00) begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else begin
            hi_d    = byte_in[DATA_W-9:0];
            sum_d   = sum_q + byte_in;
            state_d = W_LO;
          end
        end
      end
      W_LO: begin
        if (xfer) begin
          data_d  = {hi_q, byte_in};
          sum_d   = sum_q + byte_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_inc;
        state_d = (16'(cnt_inc) < len_q) ? W_HI : CSUM;
      end
      CSUM: begin
        if (xfer) begin
          hold_d = 1'b0;
          if (byte_in == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // Strobe decoded from state so an asynchronous reset drops it at once.
  assign Pm_we_out   = (state_q == WRITE);
  assign Pm_addr_out = addr_q;
  assign Pm_data_out = data_q;
  assign cpu_hold    = hold_q;
  assign done        = done_q;
  assign error       = err_q;
  assign word_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for prog_loader: random/directed frames against a frame-level model.
module tb_prog_loader;
  import pic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [10:0] Pm_addr_out;
  logic [13:0] Pm_data_out;
  logic        Pm_we_out;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [11:0] word_count;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .Pm_addr_out(Pm_addr_out),
    .Pm_data_out(Pm_data_out),
    .Pm_we_out  (Pm_we_out),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  frame[$];
  logic [10:0] exp_addr[$];
  logic [13:0] exp_data[$];
  int          exp_consumed;
  bit          exp_done;
  bit          exp_err;

  logic [10:0] mon_addr[$];
  logic [13:0] mon_data[$];
  int          ready_viol = 0;

  always @(negedge clk) begin
    if (Pm_we_out === 1'b1) begin
      mon_addr.push_back(Pm_addr_out);
      mon_data.push_back(Pm_data_out);
      if (byte_ready !== 1'b0) ready_viol++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level reference: walks the byte list and decides writes and outcome.
  task automatic model();
    int n;
    logic [7:0] s;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err  = 0;
    s = 8'h00;
    if (frame[0] !== 8'hA5) begin
      exp_err = 1; exp_consumed = 1; return;
    end
    n = {frame[1], frame[2]};
    if (n == 0 || n > 2048) begin
      exp_err = 1; exp_consumed = 3; return;
    end
    for (int i = 0; i < n; i++) begin
      logic [7:0] hi, lo;
      hi = frame[3 + 2*i];
      if (hi[7:6] != 2'b00) begin
        exp_err = 1; exp_consumed = 4 + 2*i; return;
      end
      lo = frame[4 + 2*i];
      exp_addr.push_back(11'(i));
      exp_data.push_back({hi[5:0], lo});
      s = s + hi + lo;
    end
    exp_consumed = 4 + 2*n;
    if (frame[3 + 2*n] == s) exp_done = 1;
    else exp_err = 1;
  endtask

  task automatic build_frame(input int n, input bit seq, input bit bad_csum);
    logic [7:0]  s, hi, lo;
    logic [13:0] w;
    logic [15:0] nn;
    nn = 16'(n);
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(nn[15:8]);
    frame.push_back(nn[7:0]);
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      w  = seq ? 14'(i) : 14'($urandom);
      hi = {2'b00, w[13:8]};
      lo = w[7:0];
      frame.push_back(hi);
      frame.push_back(lo);
      s = s + hi + lo;
    end
    frame.push_back(bad_csum ? s + 8'd1 : s);
  endtask

  task automatic set_basic(input logic [7:0] csum);
    logic [7:0] b [10];
    b = '{8'hA5, 8'h00, 8'h03, 8'h30, 8'h07, 8'h07, 8'hA5, 8'h01, 8'h03, 8'h00};
    b[9] = csum;
    frame.delete();
    for (int i = 0; i < 10; i++) frame.push_back(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    bit sent;
    t = 0;
    sent = 0;
    while (!sent && t < 200) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_in    = b;
        sent       = (byte_ready === 1'b1);
      end
      t++;
    end
    checks++;
    if (!sent) begin
      errors++;
      $display("FAIL send_byte: byte %h not accepted, ready=%b after %0d cycles", b, byte_ready, t);
    end
  endtask

  task automatic pulse_start(input bit chk);
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk) begin
      checks++;
      if ({byte_ready, cpu_hold, done, error, word_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 12'd0}) begin
        errors++;
        $display("FAIL start_state: ready/hold/done/err/cnt=%b/%b/%b/%b/%0d need 1/1/0/0/0",
                 byte_ready, cpu_hold, done, error, word_count);
      end
    end
  endtask

  task automatic run_frame(input bit gaps, input bit midstart, input string name);
    int nw;
    model();
    mon_addr.delete();
    mon_data.delete();
    ready_viol = 0;
    pulse_start(1);
    for (int i = 0; i < exp_consumed; i++) begin
      send_byte(frame[i], gaps);
      if (midstart && i == 4) pulse_start(0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    nw = exp_addr.size();
    checks++;
    if ({done, error, cpu_hold} !== {exp_done, exp_err, 1'b0}) begin
      errors++;
      $display("FAIL %s status: done/err/hold=%b/%b/%b need %b/%b/0", name, done, error, cpu_hold, exp_done, exp_err);
    end
    checks++;
    if (word_count !== 12'(nw)) begin
      errors++;
      $display("FAIL %s word_count: got %0d need %0d", name, word_count, nw);
    end
    checks++;
    if (mon_addr.size() != nw) begin
      errors++;
      $display("FAIL %s write_count: got %0d need %0d", name, mon_addr.size(), nw);
    end
    for (int i = 0; i < nw && i < mon_addr.size(); i++) begin
      checks++;
      if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s write%0d: addr/data=%h/%h need %h/%h", name, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (ready_viol != 0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready: ready_during_write=%0d ready_now=%b need 0/0", name, ready_viol, byte_ready);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, Pm_we_out, Pm_addr_out, Pm_data_out, cpu_hold, done, error, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b cnt=%0d need all 0",
               byte_ready, Pm_we_out, Pm_addr_out, Pm_data_out, cpu_hold, done, error, word_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_basic(8'hE7);
    run_frame(0, 0, "basic");
    checks++;
    if (mon_data.size() != 3 || mon_data[0] !== 14'h3007 || mon_data[1] !== 14'h07A5 || mon_data[2] !== 14'h0103) begin
      errors++;
      $display("FAIL basic_words: n=%0d d0=%h d1=%h d2=%h need 3 3007 07a5 0103",
               mon_data.size(), mon_data[0], mon_data[1], mon_data[2]);
    end
    checks++;
    if ({done, word_count} !== {1'b1, 12'd3}) begin
      errors++;
      $display("FAIL basic_done: done=%b cnt=%0d need 1/3", done, word_count);
    end
  endtask

  task automatic test_bad_header();
    frame.delete();
    frame.push_back(8'h5A);
    run_frame(0, 0, "bad_header");
  endtask

  task automatic test_bad_len();
    frame.delete();
    frame.push_back(8'hA5); frame.push_back(8'h00); frame.push_back(8'h00);
    run_frame(0, 0, "len_zero");
    frame.delete();
    frame.push_back(8'hA5); frame.push_back(8'h08); frame.push_back(8'h01);
    run_frame(0, 0, "len_2049");
  endtask

  task automatic test_bad_csum();
    set_basic(8'hE8);
    run_frame(0, 0, "bad_csum");
  endtask

  task automatic test_gaps_midstart();
    set_basic(8'hE7);
    run_frame(1, 1, "gaps_midstart");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 9);
      build_frame(n, 0, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) frame[3 + 2*$urandom_range(0, n-1)][7:6] = 2'(1 + $urandom_range(0, 2));
      run_frame(($urandom_range(0, 1) == 1), 0, $sformatf("random%0d", k));
    end
  endtask

  task automatic test_full();
    build_frame(2048, 1, 0);
    run_frame(0, 0, "full2048");
    checks++;
    if (mon_addr.size() != 2048 || mon_addr[2047] !== 11'd2047 || word_count !== 12'd2048 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_last: writes=%0d last_addr=%h cnt=%0d done=%b need 2048 7ff 2048 1",
               mon_addr.size(), mon_addr[mon_addr.size()-1], word_count, done);
    end
  endtask

  task automatic test_reset_midload();
    build_frame(10, 0, 0);
    mon_addr.delete();
    mon_data.delete();
    pulse_start(1);
    for (int i = 0; i < 13; i++) send_byte(frame[i], 0);
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mon_addr.size() != 5 || Pm_addr_out !== 11'd5 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL midload_pre: writes=%0d addr=%h hold=%b need 5 005 1", mon_addr.size(), Pm_addr_out, cpu_hold);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, Pm_we_out, Pm_addr_out, Pm_data_out, cpu_hold, done, error, word_count} !== '0) begin
      errors++;
      $display("FAIL midload_reset: ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b cnt=%0d need all 0",
               byte_ready, Pm_we_out, Pm_addr_out, Pm_data_out, cpu_hold, done, error, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    repeat (10) @(negedge clk);
    checks++;
    if (mon_addr.size() != 5 || byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL midload_after: writes=%0d ready=%b hold=%b need 5 0 0", mon_addr.size(), byte_ready, cpu_hold);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_bad_len();
    test_bad_csum();
    test_gaps_midstart();
    test_random();
    test_full();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
